// File: rtl/rbz_spi_defs_pkg.sv
// Definitions shared by the rbzero vector/register SPI path: FSM encoding,
// view-vector payload geometry and the SPI mode used on the link.
package rbz_spi_defs_pkg;

  localparam int RBZ_VEC_WORD_W    = 15;
  localparam int RBZ_VEC_WORDS     = 6;
  localparam int RBZ_VEC_PAYLOAD_W = RBZ_VEC_WORD_W * RBZ_VEC_WORDS;

  // Mode 0: sclk idles low, data launched on the falling edge, sampled on the rise.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TRAIL = 2'd2,
    ST_GAP   = 2'd3
  } spi_state_e;

  function automatic int rbz_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter: loading value V raises a one-cycle o_expire V+1
// cycles later, so the owner changes state exactly V+1 edges after the load.
module spi_phase_timer
  import rbz_spi_defs_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_expire
);

  logic [CNT_W-1:0] cnt_r;
  logic             run_r;
  logic             expire_r;

  // Count down from the loaded value; expire is registered one step ahead.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_r    <= CNT_W'(0);
      run_r    <= 1'b0;
      expire_r <= 1'b0;
    end else if (i_load) begin
      cnt_r    <= i_load_val;
      run_r    <= 1'b1;
      expire_r <= (i_load_val == CNT_W'(0));
    end else if (run_r && (cnt_r != CNT_W'(0))) begin
      cnt_r    <= cnt_r - CNT_W'(1);
      run_r    <= 1'b1;
      expire_r <= (cnt_r == CNT_W'(1));
    end else begin
      cnt_r    <= cnt_r;
      run_r    <= 1'b0;
      expire_r <= 1'b0;
    end
  end

  assign o_expire = expire_r;

endmodule

// File: rtl/spi_vec_sender.sv
// SPI mode-0 writer that serialises one view-vector payload into the rbzero
// vector receiver. Define RBZ_VEC_SENDER_AUTO_EN to add i_frame_tick auto-resend.
module spi_vec_sender
  import rbz_spi_defs_pkg::*;
#(
  parameter int PAYLOAD_W = RBZ_VEC_PAYLOAD_W,
  parameter int CLK_DIV   = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
`ifdef RBZ_VEC_SENDER_AUTO_EN
  input  logic                 i_frame_tick,
`endif
  input  logic                 i_start,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_csb,
  output logic                 o_sclk,
  output logic                 o_mosi
);

  localparam int BIT_W    = rbz_cnt_w(PAYLOAD_W);
  localparam int TMR_SPAN = (CLK_DIV > GAP_CYC + 1) ? CLK_DIV : GAP_CYC + 1;
  localparam int TMR_W    = rbz_cnt_w(TMR_SPAN);

  localparam logic [BIT_W-1:0] BIT_MAX   = BIT_W'(PAYLOAD_W - 1);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLK_DIV - 1);
  // The o_done cycle plus GAP_CYC idle cycles before o_ready returns.
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYC);

  spi_state_e           state_r, state_s;
  logic                 phase_high_r, phase_high_s;
  logic [BIT_W-1:0]     bitcnt_r, bitcnt_s;
  logic [PAYLOAD_W-1:0] shreg_r, shreg_s;
  logic                 csb_r, csb_s;
  logic                 sclk_r, sclk_s;
  logic                 mosi_r, mosi_s;
  logic                 ready_r, ready_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;

  logic                 tmr_load_s;
  logic [TMR_W-1:0]     tmr_val_s;
  logic                 tmr_expire_s;

  logic                 go_s;
  logic [PAYLOAD_W-1:0] go_data_s;

`ifdef RBZ_VEC_SENDER_AUTO_EN
  logic [PAYLOAD_W-1:0] last_r;
  logic                 have_last_r;

  assign go_s      = i_start || (i_frame_tick && have_last_r);
  assign go_data_s = i_start ? i_data : last_r;

  // Remember the last explicitly requested payload for tick-driven resends.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_r      <= {PAYLOAD_W{1'b0}};
      have_last_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && i_start) begin
      last_r      <= i_data;
      have_last_r <= 1'b1;
    end else begin
      last_r      <= last_r;
      have_last_r <= have_last_r;
    end
  end
`else
  assign go_s      = i_start;
  assign go_data_s = i_data;
`endif

  spi_phase_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (tmr_load_s),
    .i_load_val (tmr_val_s),
    .o_expire   (tmr_expire_s)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s      = state_r;
    phase_high_s = phase_high_r;
    bitcnt_s     = bitcnt_r;
    shreg_s      = shreg_r;
    csb_s        = csb_r;
    sclk_s       = sclk_r;
    mosi_s       = mosi_r;
    ready_s      = ready_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    tmr_load_s   = 1'b0;
    tmr_val_s    = HALF_LOAD;

    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          state_s      = ST_SHIFT;
          phase_high_s = 1'b0;
          bitcnt_s     = BIT_MAX;
          shreg_s      = go_data_s;
          csb_s        = 1'b0;
          sclk_s       = SPI_CPOL;
          mosi_s       = go_data_s[PAYLOAD_W-1];
          ready_s      = 1'b0;
          busy_s       = 1'b1;
          tmr_load_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (!tmr_expire_s) begin
          state_s = ST_SHIFT;
        end else if (!phase_high_r) begin
          tmr_load_s   = 1'b1;
          phase_high_s = 1'b1;
          sclk_s       = 1'b1;
        end else if (bitcnt_r != BIT_W'(0)) begin
          tmr_load_s   = 1'b1;
          phase_high_s = 1'b0;
          sclk_s       = 1'b0;
          shreg_s      = {shreg_r[PAYLOAD_W-2:0], 1'b0};
          mosi_s       = shreg_r[PAYLOAD_W-2];
          bitcnt_s     = bitcnt_r - BIT_W'(1);
        end else begin
          tmr_load_s   = 1'b1;
          phase_high_s = 1'b0;
          sclk_s       = 1'b0;
          state_s      = ST_TRAIL;
        end
      end

      ST_TRAIL: begin
        if (tmr_expire_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LOAD;
          csb_s      = 1'b1;
          done_s     = 1'b1;
          state_s    = ST_GAP;
        end else begin
          state_s = ST_TRAIL;
        end
      end

      ST_GAP: begin
        if (tmr_expire_s) begin
          ready_s = 1'b1;
          busy_s  = 1'b0;
          mosi_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GAP;
        end
      end

      default: begin
        state_s      = ST_IDLE;
        phase_high_s = 1'b0;
        csb_s        = 1'b1;
        sclk_s       = SPI_CPOL;
        mosi_s       = 1'b0;
        ready_s      = 1'b1;
        busy_s       = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces csb high and sclk idle at once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r      <= ST_IDLE;
      phase_high_r <= 1'b0;
      bitcnt_r     <= BIT_W'(0);
      shreg_r      <= {PAYLOAD_W{1'b0}};
      csb_r        <= 1'b1;
      sclk_r       <= SPI_CPOL;
      mosi_r       <= 1'b0;
      ready_r      <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      phase_high_r <= phase_high_s;
      bitcnt_r     <= bitcnt_s;
      shreg_r      <= shreg_s;
      csb_r        <= csb_s;
      sclk_r       <= sclk_s;
      mosi_r       <= mosi_s;
      ready_r      <= ready_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign o_ready = ready_r;
  assign o_busy  = busy_r;
  assign o_done  = done_r;
  assign o_csb   = csb_r;
  assign o_sclk  = sclk_r;
  assign o_mosi  = mosi_r;

endmodule

// File: tb/tb_spi_vec_sender.sv
// Directed bench for spi_vec_sender (16-bit payload, CLK_DIV=2, GAP_CYC=4)
// with a mode-0 receiver model sampling mosi on sclk rise.
module tb_spi_vec_sender;

  localparam int PW = 16;
  localparam int CD = 2;
  localparam int GC = 4;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_start = 1'b0;
  logic [PW-1:0] i_data = '0;
`ifdef RBZ_VEC_SENDER_AUTO_EN
  logic          i_frame_tick = 1'b0;
`endif
  logic o_ready, o_busy, o_done, o_csb, o_sclk, o_mosi;

  int vec = 0;
  int errs = 0;

  // receiver model and protocol monitors
  logic [PW-1:0] rx_sh = '0;
  int            rx_bits = 0;
  logic [PW-1:0] mon_rx = '0;
  int            mon_bits = 0;
  int            mon_frames = 0;
  int            mon_sclk_bad = 0;
  int            mon_done = 0;
  int            mon_done_bad = 0;
  int            mon_csb_low = 0;
  int            mon_mosi_bad = 0;
  logic          prev_csb = 1'b1;
  logic          prev_mosi = 1'b0;

  always #5 i_clk = ~i_clk;

  spi_vec_sender #(
    .PAYLOAD_W (PW),
    .CLK_DIV   (CD),
    .GAP_CYC   (GC)
  ) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
`ifdef RBZ_VEC_SENDER_AUTO_EN
    .i_frame_tick (i_frame_tick),
`endif
    .i_start      (i_start),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_csb        (o_csb),
    .o_sclk       (o_sclk),
    .o_mosi       (o_mosi)
  );

  always @(posedge o_sclk or negedge o_csb) begin
    if (o_sclk === 1'b1) begin
      if (o_csb !== 1'b0) mon_sclk_bad <= mon_sclk_bad + 1;
      else begin
        rx_sh   <= {rx_sh[PW-2:0], o_mosi};
        rx_bits <= rx_bits + 1;
      end
    end else begin
      rx_sh   <= '0;
      rx_bits <= 0;
    end
  end

  always @(posedge o_csb) begin
    mon_frames <= mon_frames + 1;
    mon_rx     <= rx_sh;
    mon_bits   <= rx_bits;
  end

  always @(negedge i_clk) begin
    prev_csb  <= o_csb;
    prev_mosi <= o_mosi;
    if (o_done === 1'b1) begin
      mon_done <= mon_done + 1;
      if (!(o_csb === 1'b1 && prev_csb === 1'b0)) mon_done_bad <= mon_done_bad + 1;
    end
    if (o_csb === 1'b0) mon_csb_low <= mon_csb_low + 1;
    if (o_sclk === 1'b1 && o_mosi !== prev_mosi) mon_mosi_bad <= mon_mosi_bad + 1;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_csb(input logic lvl, output int cyc);
    cyc = 0;
    while (o_csb !== lvl && cyc < 1000) begin
      tick();
      cyc++;
    end
    if (o_csb !== lvl) cyc = -1;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (o_ready !== 1'b1 && cyc < 1000) begin
      tick();
      cyc++;
    end
    if (o_ready !== 1'b1) cyc = -1;
  endtask

  // call #1 after a rising edge while idle; returns #1 after the accept edge
  task automatic send(input logic [PW-1:0] d);
    i_start = 1'b1;
    i_data  = d;
    tick();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    vec++; if (o_csb !== 1'b1)   begin errs++; $display("FAIL rst_csb: got %b want 1", o_csb); end
    vec++; if (o_sclk !== 1'b0)  begin errs++; $display("FAIL rst_sclk: got %b want 0", o_sclk); end
    vec++; if (o_mosi !== 1'b0)  begin errs++; $display("FAIL rst_mosi: got %b want 0", o_mosi); end
    vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", o_ready); end
    vec++; if (o_busy !== 1'b0)  begin errs++; $display("FAIL rst_busy: got %b want 0", o_busy); end
    vec++; if (o_done !== 1'b0)  begin errs++; $display("FAIL rst_done: got %b want 0", o_done); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    tick();
    tick();
    vec++; if (o_ready !== 1'b1 || o_csb !== 1'b1) begin
      errs++; $display("FAIL rst_idle: ready=%b csb=%b want 1/1", o_ready, o_csb);
    end
  endtask

  task automatic test_single_frame();
    int f0, d0, l0, sb0, mb0, db0, cyc;
    f0 = mon_frames; d0 = mon_done; l0 = mon_csb_low;
    sb0 = mon_sclk_bad; mb0 = mon_mosi_bad; db0 = mon_done_bad;
    send(16'hA5C3);
    vec++; if (o_csb !== 1'b0)   begin errs++; $display("FAIL acc_csb: got %b want 0", o_csb); end
    vec++; if (o_mosi !== 1'b1)  begin errs++; $display("FAIL acc_mosi: got %b want 1", o_mosi); end
    vec++; if (o_ready !== 1'b0) begin errs++; $display("FAIL acc_ready: got %b want 0", o_ready); end
    vec++; if (o_busy !== 1'b1)  begin errs++; $display("FAIL acc_busy: got %b want 1", o_busy); end
    wait_ready(cyc);
    vec++; if (cyc != 71) begin errs++; $display("FAIL sf_ready_lat: got %0d want 71", cyc); end
    vec++; if (mon_rx !== 16'hA5C3) begin errs++; $display("FAIL sf_data: got %h want a5c3", mon_rx); end
    vec++; if (mon_bits != 16) begin errs++; $display("FAIL sf_rises: got %0d want 16", mon_bits); end
    vec++; if (mon_frames - f0 != 1) begin errs++; $display("FAIL sf_frames: got %0d want 1", mon_frames - f0); end
    vec++; if (mon_done - d0 != 1) begin errs++; $display("FAIL sf_done: got %0d want 1", mon_done - d0); end
    vec++; if (mon_csb_low - l0 != 66) begin errs++; $display("FAIL sf_csb_low: got %0d want 66", mon_csb_low - l0); end
    vec++; if (mon_sclk_bad - sb0 != 0) begin errs++; $display("FAIL sf_sclk_idle: got %0d want 0", mon_sclk_bad - sb0); end
    vec++; if (mon_mosi_bad - mb0 != 0) begin errs++; $display("FAIL sf_mosi_stable: got %0d want 0", mon_mosi_bad - mb0); end
    vec++; if (mon_done_bad - db0 != 0) begin errs++; $display("FAIL sf_done_align: got %0d want 0", mon_done_bad - db0); end
    vec++; if (o_busy !== 1'b0 || o_mosi !== 1'b0) begin
      errs++; $display("FAIL sf_idle: busy=%b mosi=%b want 0/0", o_busy, o_mosi);
    end
  endtask

  task automatic test_ignore_busy();
    int f0, cyc;
    f0 = mon_frames;
    send(16'hC0DE);
    repeat (20) tick();
    i_start = 1'b1;
    i_data  = 16'h1234;
    tick();
    i_start = 1'b0;
    i_data  = 16'hFFFF;
    wait_ready(cyc);
    vec++; if (cyc < 0) begin errs++; $display("FAIL ib_timeout: got timeout want ready"); end
    repeat (100) tick();
    vec++; if (mon_frames - f0 != 1) begin errs++; $display("FAIL ib_frames: got %0d want 1", mon_frames - f0); end
    vec++; if (mon_rx !== 16'hC0DE) begin errs++; $display("FAIL ib_data: got %h want c0de", mon_rx); end
    vec++; if (o_csb !== 1'b1 || o_ready !== 1'b1) begin
      errs++; $display("FAIL ib_idle: csb=%b ready=%b want 1/1", o_csb, o_ready);
    end
  endtask

  task automatic test_back_to_back();
    int f0, cyc, gap;
    f0 = mon_frames;
    i_start = 1'b1;
    i_data  = 16'h0001;
    tick();
    i_data  = 16'h8000;
    wait_csb(1'b1, cyc);
    vec++; if (cyc != 66) begin errs++; $display("FAIL bb_len1: got %0d want 66", cyc); end
    vec++; if (mon_rx !== 16'h0001) begin errs++; $display("FAIL bb_lsb_only: got %h want 0001", mon_rx); end
    wait_csb(1'b0, gap);
    i_start = 1'b0;
    vec++; if (gap < GC) begin errs++; $display("FAIL bb_gap: got %0d want >=%0d", gap, GC); end
    wait_csb(1'b1, cyc);
    vec++; if (mon_rx !== 16'h8000) begin errs++; $display("FAIL bb_msb_only: got %h want 8000", mon_rx); end
    vec++; if (mon_bits != 16) begin errs++; $display("FAIL bb_rises: got %0d want 16", mon_bits); end
    wait_ready(cyc);
    repeat (20) tick();
    vec++; if (mon_frames - f0 != 2) begin errs++; $display("FAIL bb_frames: got %0d want 2", mon_frames - f0); end
  endtask

  task automatic test_reset_mid();
    int d0, cyc;
    d0 = mon_done;
    send(16'hFFFF);
    repeat (30) tick();
    vec++; if (o_sclk !== 1'b1) begin errs++; $display("FAIL rm_pre_sclk: got %b want 1", o_sclk); end
    #2;
    i_reset_n = 1'b0;
    #1;
    vec++; if (o_csb !== 1'b1)  begin errs++; $display("FAIL rm_csb: got %b want 1", o_csb); end
    vec++; if (o_sclk !== 1'b0) begin errs++; $display("FAIL rm_sclk: got %b want 0", o_sclk); end
    vec++; if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errs++; $display("FAIL rm_flags: ready=%b busy=%b want 1/0", o_ready, o_busy);
    end
    tick();
    tick();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    tick();
    vec++; if (mon_done != d0) begin errs++; $display("FAIL rm_no_done: got %0d want %0d", mon_done, d0); end
    send(16'h6B1D);
    wait_ready(cyc);
    vec++; if (cyc != 71) begin errs++; $display("FAIL rm_next_lat: got %0d want 71", cyc); end
    vec++; if (mon_rx !== 16'h6B1D) begin errs++; $display("FAIL rm_next_data: got %h want 6b1d", mon_rx); end
    vec++; if (mon_done - d0 != 1) begin errs++; $display("FAIL rm_next_done: got %0d want 1", mon_done - d0); end
  endtask

`ifdef RBZ_VEC_SENDER_AUTO_EN
  task automatic test_auto();
    int f0, cyc;
    i_reset_n = 1'b0;
    tick();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    tick();
    f0 = mon_frames;
    i_frame_tick = 1'b1;
    tick();
    i_frame_tick = 1'b0;
    repeat (100) tick();
    vec++; if (mon_frames != f0) begin errs++; $display("FAIL au_no_last: got %0d want %0d", mon_frames, f0); end
    send(16'hBEEF);
    wait_ready(cyc);
    repeat (3) tick();
    f0 = mon_frames;
    i_frame_tick = 1'b1;
    tick();
    i_frame_tick = 1'b0;
    wait_ready(cyc);
    vec++; if (mon_frames - f0 != 1) begin errs++; $display("FAIL au_resend_cnt: got %0d want 1", mon_frames - f0); end
    vec++; if (mon_rx !== 16'hBEEF) begin errs++; $display("FAIL au_resend: got %h want beef", mon_rx); end
    i_frame_tick = 1'b1;
    i_start = 1'b1;
    i_data = 16'h0F0F;
    tick();
    i_frame_tick = 1'b0;
    i_start = 1'b0;
    wait_ready(cyc);
    vec++; if (mon_rx !== 16'h0F0F) begin errs++; $display("FAIL au_prio: got %h want 0f0f", mon_rx); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef RBZ_VEC_SENDER_AUTO_EN
    test_auto();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
